// File: rtl/matrix_load_ctrl_if.sv
// matrix_load_ctrl_if -- bus and status bundle for the matrix load controller.
//   master : bus driver (Write/Address/WriteData out; element buses, pulses and status in)
//   slave  : the controller itself (the reverse)
//   Write       1         write strobe, one word per cycle while high
//   Address     9         byte address, word aligned
//   WriteData   Width     write data
//   ABus/BBus   32*Width  A/B element words, word k at [k*Width +: Width]
//   MultStart   1         one-cycle launch pulse to the multiplier array
//   ResultLatch 1         one-cycle capture pulse to the result registers
//   Start       Width     status: bit0 Busy, bit1 Done, bit2 Err
interface matrix_load_ctrl_if #(parameter int Width = 8);
    logic                  Write;
    logic [8:0]            Address;
    logic [Width-1:0]      WriteData;
    logic [32*Width-1:0]   ABus;
    logic [32*Width-1:0]   BBus;
    logic                  MultStart;
    logic                  ResultLatch;
    logic [Width-1:0]      Start;

    modport master (output Write, Address, WriteData,
                    input  ABus, BBus, MultStart, ResultLatch, Start);
    modport slave  (input  Write, Address, WriteData,
                    output ABus, BBus, MultStart, ResultLatch, Start);
endinterface

// File: rtl/matrix_load_ctrl.sv
// matrix_load_ctrl -- loads the A/B operand words for the matrix multiplier,
// launches a multiply on a control write and sequences the result capture.
//   Clk   : clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : matrix_load_ctrl_if.slave (write port, element buses, pulses, status)
// Address map (word aligned): 0x000-0x07C A words, 0x080-0x0FC B words,
// 0x100-0x17C results (read-only here), 0x180 control (bit0: 1 start, 0 clear).
// Optional feature macro MATRIX_WRITE_LOCK_EN: A/B writes while a multiply is
// in flight are dropped and flag Err (status bit2) until a clear or new start.
module matrix_load_ctrl #(
    parameter int Width   = 8,
    parameter int Latency = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    matrix_load_ctrl_if.slave   bus
);
    localparam int CW = (Latency > 1) ? $clog2(Latency) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic                    busy, busy_d, done, done_d, err, err_d;
    logic                    mult_q, mult_d, rlat_q, rlat_d;
    logic                    a_we, b_we;
    logic [31:0][Width-1:0]  a_q, b_q;
    logic [Width-1:0]        status;

    // Address decode; misaligned writes never select anything.
    logic wr_ok, sel_a, sel_b, sel_ctrl, locked;
    assign wr_ok    = bus.Write && (bus.Address[1:0] == 2'b00);
    assign sel_a    = wr_ok && (bus.Address[8:7] == 2'b00);
    assign sel_b    = wr_ok && (bus.Address[8:7] == 2'b01);
    assign sel_ctrl = wr_ok && (bus.Address == 9'h180);
    assign locked   = (state == LAUNCH) || (state == RUN);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        busy_d  = busy;
        done_d  = done;
        err_d   = err;
        mult_d  = 1'b0;
        rlat_d  = 1'b0;
        a_we    = sel_a;
        b_we    = sel_b;

        if (sel_ctrl && !bus.WriteData[0]) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

`ifdef MATRIX_WRITE_LOCK_EN
        if (locked) begin
            a_we = 1'b0;
            b_we = 1'b0;
            if (sel_a || sel_b) err_d = 1'b1;
        end
`endif

        // Sequencing wins over a same-cycle clear.
        case (state)
            IDLE, DONE: begin
                if (sel_ctrl && bus.WriteData[0]) begin
                    state_d = LAUNCH;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    mult_d  = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = RUN;
                cnt_d   = CW'(Latency - 1);
                // ResultLatch is high during the RUN cycle whose count is 0.
                rlat_d  = (Latency == 1);
            end
            RUN: begin
                if (cnt == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt - CW'(1);
                    rlat_d = (cnt == CW'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            mult_q <= 1'b0;
            rlat_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            busy   <= busy_d;
            done   <= done_d;
            err    <= err_d;
            mult_q <= mult_d;
            rlat_q <= rlat_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_we) a_q[bus.Address[6:2]] <= bus.WriteData;
            if (b_we) b_q[bus.Address[6:2]] <= bus.WriteData;
        end
    end

    always_comb begin
        status      = '0;
        status[2:0] = {err, done, busy};
    end

    assign bus.ABus        = a_q;
    assign bus.BBus        = b_q;
    assign bus.MultStart   = mult_q;
    assign bus.ResultLatch = rlat_q;
    assign bus.Start       = status;
endmodule

// File: tb/tb_matrix_load_ctrl.sv
module tb_matrix_load_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [255:0] exp_a, exp_b;

    always #5 clk = ~clk;

    matrix_load_ctrl_if #(.Width(8)) bus ();

    matrix_load_ctrl #(.Width(8), .Latency(4)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the edge that takes the write.
    task automatic do_write(input logic [8:0] a, input logic [7:0] d);
        bus.Write     = 1'b1;
        bus.Address   = a;
        bus.WriteData = d;
        tick();
        bus.Write     = 1'b0;
        bus.Address   = '0;
        bus.WriteData = '0;
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (bus.ABus !== '0) begin n_err++; $display("FAIL reset_abus got %h exp 0", bus.ABus); end
        n_vec++; if (bus.BBus !== '0) begin n_err++; $display("FAIL reset_bbus got %h exp 0", bus.BBus); end
        n_vec++; if (bus.MultStart !== 1'b0) begin n_err++; $display("FAIL reset_multstart got %b exp 0", bus.MultStart); end
        n_vec++; if (bus.ResultLatch !== 1'b0) begin n_err++; $display("FAIL reset_resultlatch got %b exp 0", bus.ResultLatch); end
        n_vec++; if (bus.Start !== 8'h00) begin n_err++; $display("FAIL reset_start got %h exp 00", bus.Start); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_ab_write();
        do_write(9'h008, 8'h5A);
        do_write(9'h0FC, 8'hA5);
        exp_a = '0; exp_a[2*8 +: 8] = 8'h5A;
        exp_b = '0; exp_b[31*8 +: 8] = 8'hA5;
        n_vec++; if (bus.ABus !== exp_a) begin n_err++; $display("FAIL ab_write_abus got %h exp %h", bus.ABus, exp_a); end
        n_vec++; if (bus.BBus !== exp_b) begin n_err++; $display("FAIL ab_write_bbus got %h exp %h", bus.BBus, exp_b); end
    endtask

    task automatic test_ignored();
        do_write(9'h006, 8'hFF);
        do_write(9'h104, 8'h11);
        do_write(9'h184, 8'h01);
        do_write(9'h181, 8'h01);
        do_write(9'h1FC, 8'h22);
        tick();
        n_vec++; if (bus.ABus !== exp_a) begin n_err++; $display("FAIL ignored_abus got %h exp %h", bus.ABus, exp_a); end
        n_vec++; if (bus.BBus !== exp_b) begin n_err++; $display("FAIL ignored_bbus got %h exp %h", bus.BBus, exp_b); end
        n_vec++; if (bus.Start !== 8'h00) begin n_err++; $display("FAIL ignored_start got %h exp 00", bus.Start); end
        n_vec++; if (bus.MultStart !== 1'b0) begin n_err++; $display("FAIL ignored_multstart got %b exp 0", bus.MultStart); end
    endtask

    task automatic test_start();
        logic       e_rl;
        logic [7:0] e_st;
        do_write(9'h180, 8'h01);
        n_vec++; if (bus.MultStart !== 1'b1) begin n_err++; $display("FAIL start_multstart got %b exp 1", bus.MultStart); end
        n_vec++; if (bus.Start !== 8'h01) begin n_err++; $display("FAIL start_busy got %h exp 01", bus.Start); end
        for (int i = 1; i <= 6; i++) begin
            tick();
            e_rl = (i == 4);
            e_st = (i >= 5) ? 8'h02 : 8'h01;
            n_vec++; if (bus.MultStart !== 1'b0) begin n_err++; $display("FAIL start_ms_c%0d got %b exp 0", i, bus.MultStart); end
            n_vec++; if (bus.ResultLatch !== e_rl) begin n_err++; $display("FAIL start_rl_c%0d got %b exp %b", i, bus.ResultLatch, e_rl); end
            n_vec++; if (bus.Start !== e_st) begin n_err++; $display("FAIL start_st_c%0d got %h exp %h", i, bus.Start, e_st); end
        end
    endtask

    // Starts from DONE with Done set; a second start two cycles in is ignored.
    task automatic test_back_to_back();
        logic       e_rl;
        logic [7:0] e_st;
        do_write(9'h180, 8'h01);
        n_vec++; if (bus.Start !== 8'h01) begin n_err++; $display("FAIL b2b_done_cleared got %h exp 01", bus.Start); end
        tick();
        do_write(9'h180, 8'h01);
        n_vec++; if (bus.MultStart !== 1'b0) begin n_err++; $display("FAIL b2b_second_ms got %b exp 0", bus.MultStart); end
        for (int i = 3; i <= 5; i++) begin
            tick();
            e_rl = (i == 4);
            e_st = (i == 5) ? 8'h02 : 8'h01;
            n_vec++; if (bus.ResultLatch !== e_rl) begin n_err++; $display("FAIL b2b_rl_c%0d got %b exp %b", i, bus.ResultLatch, e_rl); end
            n_vec++; if (bus.Start !== e_st) begin n_err++; $display("FAIL b2b_st_c%0d got %h exp %h", i, bus.Start, e_st); end
        end
    endtask

    task automatic test_clear();
        do_write(9'h180, 8'h00);
        n_vec++; if (bus.Start !== 8'h00) begin n_err++; $display("FAIL clear_start got %h exp 00", bus.Start); end
    endtask

    task automatic test_reset_mid_run();
        do_write(9'h180, 8'h01);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.Start !== 8'h00) begin n_err++; $display("FAIL midrst_start got %h exp 00", bus.Start); end
        n_vec++; if (bus.ABus !== '0) begin n_err++; $display("FAIL midrst_abus got %h exp 0", bus.ABus); end
        tick();
        tick();
        rst_n = 1'b1;
        do_write(9'h000, 8'h77);
        n_vec++; if (bus.ABus[7:0] !== 8'h77) begin n_err++; $display("FAIL postrst_first_write got %h exp 77", bus.ABus[7:0]); end
        for (int i = 0; i < 6; i++) begin
            n_vec++; if (bus.ResultLatch !== 1'b0) begin n_err++; $display("FAIL postrst_rl_c%0d got %b exp 0", i, bus.ResultLatch); end
            tick();
        end
        n_vec++; if (bus.Start !== 8'h00) begin n_err++; $display("FAIL postrst_start got %h exp 00", bus.Start); end
    endtask

    task automatic test_write_lock();
        do_write(9'h180, 8'h01);
        tick();
        do_write(9'h000, 8'h33);
`ifdef MATRIX_WRITE_LOCK_EN
        n_vec++; if (bus.ABus[7:0] !== 8'h77) begin n_err++; $display("FAIL lock_abus0 got %h exp 77", bus.ABus[7:0]); end
        n_vec++; if (bus.Start !== 8'h05) begin n_err++; $display("FAIL lock_start got %h exp 05", bus.Start); end
        tick(); tick(); tick();
        n_vec++; if (bus.Start !== 8'h06) begin n_err++; $display("FAIL lock_done_err got %h exp 06", bus.Start); end
`else
        n_vec++; if (bus.ABus[7:0] !== 8'h33) begin n_err++; $display("FAIL nolock_abus0 got %h exp 33", bus.ABus[7:0]); end
        n_vec++; if (bus.Start !== 8'h01) begin n_err++; $display("FAIL nolock_start got %h exp 01", bus.Start); end
        tick(); tick(); tick();
        n_vec++; if (bus.Start !== 8'h02) begin n_err++; $display("FAIL nolock_done got %h exp 02", bus.Start); end
`endif
        do_write(9'h180, 8'h00);
        n_vec++; if (bus.Start !== 8'h00) begin n_err++; $display("FAIL lock_clear got %h exp 00", bus.Start); end
    endtask

    initial begin
        bus.Write     = 1'b0;
        bus.Address   = '0;
        bus.WriteData = '0;
        test_reset();
        test_ab_write();
        test_ignored();
        test_start();
        test_back_to_back();
        test_clear();
        test_reset_mid_run();
        test_write_lock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
